// File: rtl/mux_arbiter.sv
// N-channel registered mux with valid/ready handshake, round-robin or fixed-priority
// arbitration, and packet locking so multi-beat packets are never interleaved.
module mux_arbiter #(
  parameter int unsigned WIDTH    = 64,
  parameter int unsigned CHANNELS = 4,
  localparam int unsigned SW      = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mode,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS-1:0]       in_last,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic [CHANNELS-1:0]       in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_last,
  output logic [SW-1:0]             out_sel,
  input  logic                      out_ready
);

  localparam logic [SW-1:0] LastCh = SW'(CHANNELS - 1);

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e        state_q;
  logic [SW-1:0] rr_ptr_q;
  logic [SW-1:0] lock_ch_q;
  logic          lock_mode_q;

  logic [WIDTH-1:0] ch_data [CHANNELS];
  logic [SW-1:0]    grant;
  logic             grant_hit;
  logic             space;
  logic             load;
  logic             eff_mode;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_split
    assign ch_data[c] = in_data[c*WIDTH +: WIDTH];
  end

  // Mode only matters when a new packet is arbitrated; a locked packet keeps the
  // mode that was live when it started.
  assign eff_mode = (state_q == StIdle) ? mode : lock_mode_q;

  always_comb begin
    grant     = '0;
    grant_hit = 1'b0;
    if (state_q == StLocked) begin
      grant     = lock_ch_q;
      grant_hit = in_valid[lock_ch_q];
    end else if (mode) begin
      for (int i = int'(CHANNELS) - 1; i >= 0; i--) begin
        if (in_valid[i]) begin
          grant     = SW'(i);
          grant_hit = 1'b1;
        end
      end
    end else begin
      // Descending offset so the closest channel after rr_ptr is assigned last.
      for (int k = int'(CHANNELS) - 1; k >= 0; k--) begin
        if (in_valid[(int'(rr_ptr_q) + k) % CHANNELS]) begin
          grant     = SW'((int'(rr_ptr_q) + k) % CHANNELS);
          grant_hit = 1'b1;
        end
      end
    end
  end

  assign space = !out_valid || out_ready;
  assign load  = rst_n && space && grant_hit;

  always_comb begin
    in_ready = '0;
    if (load) in_ready[grant] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_last    <= 1'b0;
      out_sel     <= '0;
      rr_ptr_q    <= '0;
      lock_ch_q   <= '0;
      lock_mode_q <= 1'b0;
      state_q     <= StIdle;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= ch_data[grant];
      out_last  <= in_last[grant];
      out_sel   <= grant;
      if (!eff_mode && in_last[grant]) begin
        rr_ptr_q <= (grant == LastCh) ? '0 : grant + 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (!in_last[grant]) begin
            state_q     <= StLocked;
            lock_ch_q   <= grant;
            lock_mode_q <= mode;
          end
        end
        StLocked: begin
          if (in_last[grant]) state_q <= StIdle;
        end
      endcase
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed bench for mux_arbiter: a 4-channel instance driven from a vector table plus
// hand sequences, and a 2-channel instance checking plain 2:1 mux behaviour.
module tb_mux_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 4-channel DUT
  logic         mode;
  logic [3:0]   in_valid, in_last, in_ready;
  logic [255:0] in_data;
  logic         out_valid, out_last, out_ready;
  logic [63:0]  out_data;
  logic [1:0]   out_sel;

  // 2-channel DUT
  logic         mode2;
  logic [1:0]   in_valid2, in_last2, in_ready2;
  logic [127:0] in_data2;
  logic         out_valid2, out_last2, out_ready2;
  logic [63:0]  out_data2;
  logic [0:0]   out_sel2;

  mux_arbiter #(.WIDTH(64), .CHANNELS(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in_last(in_last),
    .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_last(out_last), .out_sel(out_sel), .out_ready(out_ready)
  );

  mux_arbiter #(.WIDTH(64), .CHANNELS(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .mode(mode2), .in_valid(in_valid2), .in_last(in_last2),
    .in_data(in_data2), .in_ready(in_ready2), .out_valid(out_valid2), .out_data(out_data2),
    .out_last(out_last2), .out_sel(out_sel2), .out_ready(out_ready2)
  );

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [63:0] pat(int i);
    return 64'h0123_4567_89AB_CD00 + 64'(i);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       md;
    logic [3:0] v;
    logic [3:0] l;
    logic       rdy;
    logic [3:0] e_rdy;
    logic       e_ov;
    logic [1:0] e_sel;
    logic       e_ol;
  } vec_t;

  vec_t tbl [18];

  initial begin
    // mode, valid, last, out_ready | in_ready, out_valid, out_sel, out_last
    tbl = '{
      // round-robin, all valid single-beat packets, wraps 3 -> 0
      '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1},
      '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1},
      '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1},
      '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b1},
      '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1},
      '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1},
      // nothing valid: drain
      '{1'b0, 4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0},
      // fixed priority ch0 over ch2, then ch2 once ch0 drops
      '{1'b1, 4'b0101, 4'b0101, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1},
      '{1'b1, 4'b0101, 4'b0101, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1},
      '{1'b1, 4'b0100, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1},
      '{1'b1, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0},
      // rr_ptr is 2 here: single ch0 beat moves it to 1
      '{1'b0, 4'b0001, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1},
      // ch1 3-beat packet with a gap; mode flip while locked is ignored
      '{1'b0, 4'b0111, 4'b0101, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b0},
      '{1'b0, 4'b0111, 4'b0101, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b0},
      '{1'b1, 4'b0101, 4'b0101, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0},
      '{1'b1, 4'b0111, 4'b0111, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1},
      // round-robin resumes at ch2, then ch0
      '{1'b0, 4'b0101, 4'b0101, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1},
      '{1'b0, 4'b0101, 4'b0101, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1}
    };

    for (int c = 0; c < 4; c++) in_data[c*64 +: 64] = pat(c);
    in_data2   = {64'hD, 64'hB};
    mode       = 1'b0;
    mode2      = 1'b1;
    in_valid   = 4'b1111;
    in_last    = 4'b1111;
    out_ready  = 1'b1;
    in_valid2  = 2'b11;
    in_last2   = 2'b11;
    out_ready2 = 1'b1;

    // Reset state, with inputs valid to show in_ready is gated off
    rst_n = 1'b0;
    #3;
    check("reset in_ready", in_ready, 4'b0000);
    check("reset out_valid", out_valid, 1'b0);
    check("reset out_data", out_data, 64'h0);
    check("reset out_sel", out_sel, 2'd0);
    check("reset out_last", out_last, 1'b0);
    check("reset in_ready2", in_ready2, 2'b00);
    in_valid  = '0;
    in_valid2 = '0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      mode      = tbl[i].md;
      in_valid  = tbl[i].v;
      in_last   = tbl[i].l;
      out_ready = tbl[i].rdy;
      #1;
      check($sformatf("vec%0d in_ready", i), in_ready, tbl[i].e_rdy);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d out_valid", i), out_valid, tbl[i].e_ov);
      if (tbl[i].e_ov) begin
        check($sformatf("vec%0d out_sel", i), out_sel, tbl[i].e_sel);
        check($sformatf("vec%0d out_last", i), out_last, tbl[i].e_ol);
        check($sformatf("vec%0d out_data", i), out_data, pat(int'(tbl[i].e_sel)));
      end
    end

    // Backpressure: rr_ptr = 1, ch3 beat then stall with ch0 queued
    @(negedge clk);
    mode = 1'b0;
    in_data[3*64 +: 64] = 64'hDEADBEEF_0000000B;
    in_valid  = 4'b1000;
    in_last   = 4'b1000;
    out_ready = 1'b1;
    #1;
    check("bp load in_ready", in_ready, 4'b1000);
    @(posedge clk);
    #1;
    check("bp load out_sel", out_sel, 2'd3);
    check("bp load out_data", out_data, 64'hDEADBEEF_0000000B);
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      in_valid  = 4'b0001;
      in_last   = 4'b0001;
      out_ready = 1'b0;
      #1;
      check($sformatf("bp stall%0d in_ready", s), in_ready, 4'b0000);
      @(posedge clk);
      #1;
      check($sformatf("bp stall%0d out_data", s), out_data, 64'hDEADBEEF_0000000B);
      check($sformatf("bp stall%0d out_valid", s), out_valid, 1'b1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    check("bp release in_ready", in_ready, 4'b0001);
    @(posedge clk);
    #1;
    check("bp next out_sel", out_sel, 2'd0);
    check("bp next out_data", out_data, pat(0));
    @(negedge clk);
    in_valid = 4'b0000;
    @(posedge clk);
    #1;
    check("bp drained out_valid", out_valid, 1'b0);

    // Async reset mid-packet: rr_ptr = 1, ch1 starts a packet
    @(negedge clk);
    in_valid = 4'b0010;
    in_last  = 4'b0000;
    #1;
    check("rst pkt in_ready", in_ready, 4'b0010);
    @(posedge clk);
    #1;
    check("rst pkt out_sel", out_sel, 2'd1);
    check("rst pkt out_last", out_last, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async out_valid", out_valid, 1'b0);
    check("async out_data", out_data, 64'h0);
    check("async out_sel", out_sel, 2'd0);
    check("async in_ready", in_ready, 4'b0000);
    @(negedge clk);
    #2;
    rst_n    = 1'b1;
    in_valid = 4'b0100;
    in_last  = 4'b0100;
    #1;
    check("post-rst in_ready", in_ready, 4'b0100);
    @(posedge clk);
    #1;
    check("post-rst out_sel", out_sel, 2'd2);
    check("post-rst out_last", out_last, 1'b1);
    // Back in IDLE with rr_ptr = 3: a stale ch1 lock would grant ch1 here
    @(negedge clk);
    in_valid = 4'b0011;
    in_last  = 4'b0011;
    #1;
    check("post-rst idle in_ready", in_ready, 4'b0001);
    @(posedge clk);
    #1;
    check("post-rst idle out_sel", out_sel, 2'd0);
    @(negedge clk);
    in_valid = 4'b0000;

    // 2:1 equivalence, fixed priority
    @(negedge clk);
    in_valid2 = 2'b10;
    in_last2  = 2'b11;
    #1;
    check("2to1 ch1 in_ready", in_ready2, 2'b10);
    @(posedge clk);
    #1;
    check("2to1 ch1 out_data", out_data2, 64'hD);
    check("2to1 ch1 out_sel", out_sel2, 1'b1);
    @(negedge clk);
    in_valid2 = 2'b01;
    #1;
    check("2to1 ch0 in_ready", in_ready2, 2'b01);
    @(posedge clk);
    #1;
    check("2to1 ch0 out_data", out_data2, 64'hB);
    check("2to1 ch0 out_sel", out_sel2, 1'b0);
    @(negedge clk);
    in_valid2 = 2'b00;
    @(posedge clk);
    #1;
    check("2to1 drain out_valid", out_valid2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
